// File: rtl/cgol_pkg.sv
// Shared types and helpers for the Game of Life generation buffer.
// Window-edge helpers return -1 for a neighbour row that lies outside the grid.
package cgol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        SWAP
    } gen_state_t;

    localparam int COLS_DEF = 8;
    localparam int ROWS_DEF = 16;

    function automatic int wrap_prev(input int idx, input int rows, input bit torus);
        if (idx == 0)
            return torus ? rows - 1 : -1;
        return idx - 1;
    endfunction

    function automatic int wrap_next(input int idx, input int rows, input bit torus);
        if (idx == rows - 1)
            return torus ? 0 : -1;
        return idx + 1;
    endfunction

endpackage

// File: rtl/cgol_bank.sv
// One ROWS x COLS cell bank: flop array with async clear, one write port,
// three combinational window read ports and one display read port.
module cgol_bank #(
    parameter int COLS = 8,
    parameter int ROWS = 16,
    parameter int AW   = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [COLS-1:0] wdata,
    input  logic [AW-1:0]   a_addr,
    input  logic [AW-1:0]   c_addr,
    input  logic [AW-1:0]   b_addr,
    input  logic [AW-1:0]   d_addr,
    output logic [COLS-1:0] a_data,
    output logic [COLS-1:0] c_data,
    output logic [COLS-1:0] b_data,
    output logic [COLS-1:0] d_data
);

    localparam logic [AW:0] ROWS_W = (AW + 1)'(ROWS);

    logic [COLS-1:0] mem [ROWS];

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < ROWS_W;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++)
                mem[i] <= '0;
        end else if (we && in_range(waddr)) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses beyond the grid (only possible for non-power-of-two ROWS) read as zero.
    assign a_data = in_range(a_addr) ? mem[a_addr] : '0;
    assign c_data = in_range(c_addr) ? mem[c_addr] : '0;
    assign b_data = in_range(b_addr) ? mem[b_addr] : '0;
    assign d_data = in_range(d_addr) ? mem[d_addr] : '0;

endmodule

// File: rtl/cgol_gen_buffer.sv
// Double-buffered cell store: streams row windows of the current generation,
// collects result rows into the next bank, and swaps banks per generation.
module cgol_gen_buffer
    import cgol_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int AW    = $clog2(ROWS),
    parameter int TORUS = 1,
    parameter int GW    = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [COLS-1:0] load_data,
    input  logic            start,
    output logic            idle,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [AW-1:0]   row_idx,
    output logic [COLS-1:0] row_above,
    output logic [COLS-1:0] row_cur,
    output logic [COLS-1:0] row_below,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [COLS-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [COLS-1:0] rd_data,
    output logic            gen_done,
    output logic [GW-1:0]   gen_count
);

    localparam logic [AW:0]   ROWS_W = (AW + 1)'(ROWS);
    localparam logic [AW-1:0] LAST   = AW'(ROWS - 1);

    gen_state_t      state;
    logic            bank_sel;
    logic [ROWS-1:0] mask;

    logic [AW-1:0]   win_idx;
    int              prev_i;
    int              next_i;
    logic [AW-1:0]   a_addr;
    logic [AW-1:0]   b_addr;
    logic            load_ok;
    logic            res_ok;
    logic            res_in_range;

    logic [1:0]      bank_we;
    logic [AW-1:0]   bank_waddr [2];
    logic [COLS-1:0] bank_wdata [2];
    logic [COLS-1:0] q_a [2];
    logic [COLS-1:0] q_c [2];
    logic [COLS-1:0] q_b [2];
    logic [COLS-1:0] q_d [2];

    logic [COLS-1:0] win_above;
    logic [COLS-1:0] win_cur;
    logic [COLS-1:0] win_below;
    logic [COLS-1:0] disp_data;

    // The window fetched is the one that will be presented after the coming edge.
    always_comb begin
        win_idx = (state == IDLE) ? '0 : row_idx + AW'(1);
        prev_i  = wrap_prev(int'(win_idx), ROWS, TORUS != 0);
        next_i  = wrap_next(int'(win_idx), ROWS, TORUS != 0);
        a_addr  = (prev_i < 0) ? '0 : AW'(prev_i);
        b_addr  = (next_i < 0) ? '0 : AW'(next_i);
    end

    assign load_ok      = (state == IDLE) && load_en && !start;
    assign res_ok       = ((state == STREAM) || (state == DRAIN)) && wr_en;
    assign res_in_range = {1'b0, wr_addr} < ROWS_W;

    // The current bank takes host loads; the other bank takes result rows.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (bank_sel == b[0]) begin
                bank_we[b]    = load_ok;
                bank_waddr[b] = load_addr;
                bank_wdata[b] = load_data;
            end else begin
                bank_we[b]    = res_ok;
                bank_waddr[b] = wr_addr;
                bank_wdata[b] = wr_data;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        cgol_bank #(
            .COLS(COLS),
            .ROWS(ROWS),
            .AW  (AW)
        ) u_bank (
            .clk    (clk),
            .reset_n(reset_n),
            .we     (bank_we[g]),
            .waddr  (bank_waddr[g]),
            .wdata  (bank_wdata[g]),
            .a_addr (a_addr),
            .c_addr (win_idx),
            .b_addr (b_addr),
            .d_addr (rd_addr),
            .a_data (q_a[g]),
            .c_data (q_c[g]),
            .b_data (q_b[g]),
            .d_data (q_d[g])
        );
    end

    always_comb begin
        win_above = (prev_i < 0) ? '0 : q_a[bank_sel];
        win_cur   = q_c[bank_sel];
        win_below = (next_i < 0) ? '0 : q_b[bank_sel];
        disp_data = q_d[bank_sel];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bank_sel  <= 1'b0;
            mask      <= '0;
            idle      <= 1'b1;
            row_valid <= 1'b0;
            row_idx   <= '0;
            row_above <= '0;
            row_cur   <= '0;
            row_below <= '0;
            rd_data   <= '0;
            gen_done  <= 1'b0;
            gen_count <= '0;
        end else begin
            gen_done <= 1'b0;
            rd_data  <= disp_data;
            if (res_ok && res_in_range)
                mask[wr_addr] <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        mask      <= '0;
                        row_idx   <= '0;
                        row_above <= win_above;
                        row_cur   <= win_cur;
                        row_below <= win_below;
                        row_valid <= 1'b1;
                        idle      <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (row_valid && row_ready) begin
                        if (row_idx == LAST) begin
                            row_valid <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            row_idx   <= win_idx;
                            row_above <= win_above;
                            row_cur   <= win_cur;
                            row_below <= win_below;
                        end
                    end
                end
                DRAIN: begin
                    if (&mask)
                        state <= SWAP;
                end
                SWAP: begin
                    bank_sel  <= ~bank_sel;
                    gen_done  <= 1'b1;
                    gen_count <= gen_count + GW'(1);
                    idle      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
